sobel_window_buffer: RTL and testbench



---
 rtl/sobel_window_buffer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_sobel_window_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_buffer.sv
// ----------------------------------------------------------------------------
// sobel_window_buffer
//
// Producer side of the Sobel window interface. Accepts a raster-order 8-bit
// pixel stream, keeps two line buffers (rows r-1 and r-2) plus a short shift
// register per window row, and presents each complete 3x3 neighbourhood as
// three 24-bit row words together with the multiplier start/enable level.
//
// Row word packing: [23:16] = column c-2, [15:8] = column c-1, [7:0] = column c.
//
// Parameters:
//   IMG_WIDTH   pixels per row  (>= 3)
//   IMG_HEIGHT  rows per frame  (>= 3)
//   CNTW        width of the column/row counters
//
// Ports:
//   clk                input   system clock, rising edge
//   reset              input   asynchronous, active-high; clears all state
//   frameStart         input   one-cycle pulse; arms/restarts frame capture
//   pixelIn[7:0]       input   unsigned pixel, raster order
//   pixelValid         input   pixelIn valid this cycle
//   pixelReady         output  block accepts a pixel this cycle
//   sobelHoldOutA[23:0] output top row of window    (row r-2)
//   sobelHoldOutB[23:0] output middle row of window (row r-1)
//   sobelHoldOutC[23:0] output bottom row of window (row r)
//   windowValid        output  window outputs valid this cycle
//   startMultiplierEn  output  level, high from first window through the last
//   frameDone          output  one-cycle pulse with the final window of a frame
//   windowCount[23:0]  output  windows emitted since frameStart
//                              (present only when SOBEL_WIN_STATS_EN is defined)
//
// Optional feature macro: SOBEL_WIN_STATS_EN
// ----------------------------------------------------------------------------
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 1024,
  parameter int CNTW       = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [7:0]  pixelIn,
  input  logic        pixelValid,
  output logic        pixelReady,
  output logic [23:0] sobelHoldOutA,
  output logic [23:0] sobelHoldOutB,
  output logic [23:0] sobelHoldOutC,
  output logic        windowValid,
  output logic        startMultiplierEn,
  output logic        frameDone
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic [23:0] windowCount
`endif
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNTW-1:0] COL_LAST = CNTW'(IMG_WIDTH - 1);
  localparam logic [CNTW-1:0] ROW_LAST = CNTW'(IMG_HEIGHT - 1);
  localparam logic [CNTW-1:0] CNT_TWO  = CNTW'(2);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] col_q, col_d;
  logic [CNTW-1:0] row_q, row_d;
  logic            en_q, en_d;

  // Two previous pixels of each window row; the current pixel completes the word.
  logic [15:0]     a_sr_q, b_sr_q, c_sr_q;
  logic [23:0]     hold_a_q, hold_b_q, hold_c_q;
  logic            win_valid_q;
  logic            done_q;

  logic [7:0]      line_a_q [0:IMG_WIDTH-1];
  logic [7:0]      line_b_q [0:IMG_WIDTH-1];

  logic            ready_s;
  logic            accept_s;
  logic [CNTW-1:0] col_cur_s;
  logic [CNTW-1:0] row_cur_s;
  logic [AW-1:0]   addr_s;
  logic [7:0]      line_a_rd_s;
  logic [7:0]      line_b_rd_s;
  logic [23:0]     a_word_s, b_word_s, c_word_s;
  logic            win_s;
  logic            last_s;

`ifdef SOBEL_WIN_STATS_EN
  logic [23:0]     win_cnt_q, win_cnt_d;
`endif

  // A pixel arriving with frameStart is pixel (0,0) of the new frame, so the
  // effective coordinates are forced to zero in that cycle.
  assign accept_s    = pixelValid & ready_s;
  assign col_cur_s   = frameStart ? '0 : col_q;
  assign row_cur_s   = frameStart ? '0 : row_q;
  assign addr_s      = col_cur_s[AW-1:0];

  // Line buffers are read before the write of the same edge lands.
  assign line_a_rd_s = line_a_q[addr_s];
  assign line_b_rd_s = line_b_q[addr_s];

  assign a_word_s    = {a_sr_q, line_a_rd_s};
  assign b_word_s    = {b_sr_q, line_b_rd_s};
  assign c_word_s    = {c_sr_q, pixelIn};

  // Columns 0 and 1 never complete a window, so a window never spans two rows
  // even though the shift registers carry over from the previous row.
  assign win_s  = accept_s && (row_cur_s >= CNT_TWO) && (col_cur_s >= CNT_TWO);
  assign last_s = accept_s && !frameStart &&
                  ((state_q == FILL) || (state_q == STREAM)) &&
                  (row_cur_s == ROW_LAST) && (col_cur_s == COL_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frameStart) begin
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // A 3x3 image has its first window on its last pixel.
        if (frameStart) begin
          state_d = FILL;
        end else if (last_s) begin
          state_d = DONE;
        end else if (win_s) begin
          state_d = STREAM;
        end else begin
          state_d = FILL;
        end
      end
      STREAM: begin
        if (frameStart) begin
          state_d = FILL;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        if (frameStart) begin
          state_d = FILL;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: ready while capturing, or whenever a new frame is being armed.
  always_comb begin
    ready_s = 1'b0;
    if (frameStart) begin
      ready_s = 1'b1;
    end else if ((state_q == FILL) || (state_q == STREAM)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign pixelReady = ready_s;

  // Column/row counters for the next accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frameStart) begin
      // IMG_WIDTH >= 3, so a pixel taken as (0,0) never wraps the row.
      col_d = accept_s ? CNT_ONE : '0;
      row_d = '0;
    end else if (accept_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + CNT_ONE;
      end else begin
        col_d = col_q + CNT_ONE;
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Multiplier enable: rises with the first window and stays high through the
  // final window, dropping on the edge that ends the frameDone pulse.
  always_comb begin
    en_d = en_q;
    if (frameStart) begin
      en_d = 1'b0;
    end else if (done_q) begin
      en_d = 1'b0;
    end else if (win_s) begin
      en_d = 1'b1;
    end else begin
      en_d = en_q;
    end
  end

  // Counters and enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      en_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      en_q  <= en_d;
    end
  end

  // Per-row shift registers advance on every accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr_q <= 16'h0000;
      b_sr_q <= 16'h0000;
      c_sr_q <= 16'h0000;
    end else if (accept_s) begin
      a_sr_q <= a_word_s[15:0];
      b_sr_q <= b_word_s[15:0];
      c_sr_q <= c_word_s[15:0];
    end
  end

  // Line buffer RAMs: row r-1 moves into the r-2 buffer as row r is written.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_a_q[addr_s] <= line_b_rd_s;
      line_b_q[addr_s] <= pixelIn;
    end
  end

  // Registered window outputs; the row words hold between windows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a_q    <= 24'h000000;
      hold_b_q    <= 24'h000000;
      hold_c_q    <= 24'h000000;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      win_valid_q <= win_s;
      done_q      <= last_s;
      if (win_s) begin
        hold_a_q <= a_word_s;
        hold_b_q <= b_word_s;
        hold_c_q <= c_word_s;
      end
    end
  end

  assign sobelHoldOutA     = hold_a_q;
  assign sobelHoldOutB     = hold_b_q;
  assign sobelHoldOutC     = hold_c_q;
  assign windowValid       = win_valid_q;
  assign startMultiplierEn = en_q;
  assign frameDone         = done_q;

`ifdef SOBEL_WIN_STATS_EN
  // Window statistics: restarts with each frame, holds after the frame ends.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (frameStart) begin
      win_cnt_d = 24'h000000;
    end else if (win_s) begin
      win_cnt_d = win_cnt_q + 24'h000001;
    end else begin
      win_cnt_d = win_cnt_q;
    end
  end

  // Window statistics register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= 24'h000000;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign windowCount = win_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// ----------------------------------------------------------------------------
// tb_sobel_window_buffer
//
// Directed bench for sobel_window_buffer on a 4x4 image, pixel = row*16+col
// (plus an offset for the restarted frame). Expected row words are built from
// the pixel formula, independent of the design's buffering.
// ----------------------------------------------------------------------------
module tb_sobel_window_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        frameStart;
  logic [7:0]  pixelIn;
  logic        pixelValid;
  logic        pixelReady;
  logic [23:0] sobelHoldOutA;
  logic [23:0] sobelHoldOutB;
  logic [23:0] sobelHoldOutC;
  logic        windowValid;
  logic        startMultiplierEn;
  logic        frameDone;
`ifdef SOBEL_WIN_STATS_EN
  logic [23:0] windowCount;
`endif

  int          n_chk;
  int          n_pass;
  int          win_cnt;
  logic [23:0] exp_a;
  logic [23:0] exp_b;
  logic [23:0] exp_c;

  sobel_window_buffer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .CNTW       (11)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frameStart        (frameStart),
    .pixelIn           (pixelIn),
    .pixelValid        (pixelValid),
    .pixelReady        (pixelReady),
    .sobelHoldOutA     (sobelHoldOutA),
    .sobelHoldOutB     (sobelHoldOutB),
    .sobelHoldOutC     (sobelHoldOutC),
    .windowValid       (windowValid),
    .startMultiplierEn (startMultiplierEn),
    .frameDone         (frameDone)
`ifdef SOBEL_WIN_STATS_EN
    ,
    .windowCount       (windowCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk = n_chk + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
    return base + 8'(r * 16 + c);
  endfunction

  function automatic logic [23:0] row_word(input logic [7:0] base, input int r, input int c);
    return {pix(base, r, c - 2), pix(base, r, c - 1), pix(base, r, c)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frameStart = 1'b1;
    pixelValid = 1'b0;
    step();
    frameStart = 1'b0;
    win_cnt    = 0;
    check_eq("ready_after_start", 32'(pixelReady), 32'd1);
  endtask

  // Feeds raster indices first_idx..last_idx and checks every output after
  // each accepting edge; optional idle cycles are inserted before some pixels.
  task automatic run_frame(input logic [7:0] base, input bit gaps,
                           input int first_idx, input int last_idx);
    for (int idx = first_idx; idx <= last_idx; idx++) begin
      int r;
      int c;
      bit is_win;
      r = idx / W;
      c = idx % W;
      if (gaps && ((idx % 3) == 1)) begin
        pixelValid = 1'b0;
        for (int g = 0; g < 1 + (idx % 2); g++) begin
          step();
          check_eq("gap_wv", 32'(windowValid), 32'd0);
          check_eq("gap_done", 32'(frameDone), 32'd0);
          check_eq("gap_hold_c", 32'(sobelHoldOutC), 32'(exp_c));
        end
      end
      pixelValid = 1'b1;
      pixelIn    = pix(base, r, c);
      step();
      pixelValid = 1'b0;
      is_win = (r >= 2) && (c >= 2);
      if (is_win) begin
        exp_a   = row_word(base, r - 2, c);
        exp_b   = row_word(base, r - 1, c);
        exp_c   = row_word(base, r, c);
        win_cnt = win_cnt + 1;
      end
      check_eq("wv", 32'(windowValid), 32'(is_win));
      check_eq("win_a", 32'(sobelHoldOutA), 32'(exp_a));
      check_eq("win_b", 32'(sobelHoldOutB), 32'(exp_b));
      check_eq("win_c", 32'(sobelHoldOutC), 32'(exp_c));
      check_eq("frame_done", 32'(frameDone), 32'(idx == W * H - 1));
      check_eq("mult_en", 32'(startMultiplierEn), 32'(idx >= 2 * W + 2));
    end
  endtask

  task automatic post_frame();
    check_eq("win_count", 32'(win_cnt), 32'((W - 2) * (H - 2)));
    step();
    check_eq("post_done", 32'(frameDone), 32'd0);
    check_eq("post_en", 32'(startMultiplierEn), 32'd0);
    check_eq("post_ready", 32'(pixelReady), 32'd0);
    check_eq("post_wv", 32'(windowValid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, 32'(sobelHoldOutA), 32'd0);
    check_eq({tag, "_b"}, 32'(sobelHoldOutB), 32'd0);
    check_eq({tag, "_c"}, 32'(sobelHoldOutC), 32'd0);
    check_eq({tag, "_wv"}, 32'(windowValid), 32'd0);
    check_eq({tag, "_en"}, 32'(startMultiplierEn), 32'd0);
    check_eq({tag, "_done"}, 32'(frameDone), 32'd0);
    check_eq({tag, "_ready"}, 32'(pixelReady), 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    win_cnt    = 0;
    exp_a      = 24'h000000;
    exp_b      = 24'h000000;
    exp_c      = 24'h000000;
    reset      = 1'b1;
    frameStart = 1'b0;
    pixelValid = 1'b0;
    pixelIn    = 8'h00;

    // Reset state.
    #12;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("idle_ready", 32'(pixelReady), 32'd0);

    // Continuous full frame.
    start_frame();
    run_frame(8'h00, 1'b0, 0, W * H - 1);
    post_frame();
`ifdef SOBEL_WIN_STATS_EN
    check_eq("stats_final", 32'(windowCount), 32'd4);
    step();
    check_eq("stats_hold", 32'(windowCount), 32'd4);
    start_frame();
    check_eq("stats_clear", 32'(windowCount), 32'd0);
`else
    start_frame();
`endif

    // Same frame with idle gaps (pixelValid low) between pixels.
    run_frame(8'h00, 1'b1, 0, W * H - 1);
    post_frame();

    // Mid-frame restart after the first window; the restart cycle also
    // carries pixel (0,0) of the new frame.
    start_frame();
    run_frame(8'h00, 1'b0, 0, 2 * W + 3);
    check_eq("abort_en_before", 32'(startMultiplierEn), 32'd1);
    frameStart = 1'b1;
    pixelValid = 1'b1;
    pixelIn    = 8'h80;
    #1;
    check_eq("abort_ready", 32'(pixelReady), 32'd1);
    step();
    frameStart = 1'b0;
    pixelValid = 1'b0;
    check_eq("abort_done", 32'(frameDone), 32'd0);
    check_eq("abort_en", 32'(startMultiplierEn), 32'd0);
    check_eq("abort_wv", 32'(windowValid), 32'd0);
    win_cnt = 0;
    run_frame(8'h80, 1'b0, 1, W * H - 1);
    post_frame();

    // Asynchronous reset between edges while streaming.
    start_frame();
    run_frame(8'h00, 1'b0, 0, 3 * W);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_a = 24'h000000;
    exp_b = 24'h000000;
    exp_c = 24'h000000;
    @(negedge clk);
    reset = 1'b0;
    // frameStart from IDLE with a pixel present: pixel becomes (0,0).
    frameStart = 1'b1;
    pixelValid = 1'b1;
    pixelIn    = 8'h00;
    #1;
    check_eq("idle_start_ready", 32'(pixelReady), 32'd1);
    step();
    frameStart = 1'b0;
    pixelValid = 1'b0;
    check_eq("idle_start_wv", 32'(windowValid), 32'd0);
    win_cnt = 0;
    run_frame(8'h00, 1'b0, 1, W * H - 1);
    post_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
